avalon_msg_generator: RTL and testbench
=======================================

# avalon_msg_generator

Avalon-ST message transmitter. Accepts a command carrying a byte length and a seed, then emits one well-formed message on an Avalon-ST master port: sop on the first beat, eop on the last beat, correct empty, and zeroed unused bytes. It sits upstream of `avalon_enforcer` and any Avalon-ST consumer, as the traffic source for datapath bring-up and loopback tests. Output must pass `avalon_enforcer` with no indication ever asserted.

## Interface
- `DATA_WIDTH_IN_BYTES`, default 16: beat width in bytes (W); must be a power of two and at least 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd_rdy`  out  1  the generator accepts a command this cycle.
- `cmd_len_bytes`  in  16  message length in bytes.
- `cmd_seed`  in  8  value of the first payload byte.
- `msg_out`  avalon_st_if.master  n/a  carries `valid`, `rdy` (input), `sop`, `eop`, `data` [W*8-1:0] and `empty` [log2up_func(W)-1:0]; readyLatency 0.
- `zero_len_indi`  out  1  one-cycle pulse when a zero-length command is accepted.
- `msg_cnt`  out  16  count of completed messages (eop handshakes); wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: `cmd_rdy`=1, `msg_out.valid`=0.
  - SEND: `cmd_rdy`=0; beats are presented on `msg_out`.
- Command accept is `cmd_valid & cmd_rdy`.
  - If `cmd_len_bytes`=0: the command is dropped, `zero_len_indi` pulses on the next cycle, and the state stays IDLE.
  - Otherwise: length and seed are latched, `bytes_left`=len, `next_byte`=seed, and the state moves to SEND.
- Beat contents in SEND:
  - Byte i of a beat (i=0 is the first byte in stream order) sits at `data[(W-i)*8-1 -: 8]`, so the MSB byte is first.
  - Byte value is `next_byte + i`, mod 256.
- `sop` is 1 only on the first beat of the message.
- When `bytes_left > W`:
  - The beat is full: `eop`=0, `empty`=0.
  - On handshake: `bytes_left -= W`, `next_byte += W` (mod 256), `sop` clears.
- When `bytes_left <= W`:
  - The beat is the last one: `eop`=1, `empty` = W - `bytes_left`.
  - The `empty` low-order bytes are forced to 0.
  - On handshake: the state returns to IDLE and `msg_cnt` increments.
- A single-beat message (len <= W) has `sop`=1 and `eop`=1 on the same beat.
- Beat count is ceil(len/W). Internal byte counters are 16 bits wide; there is no overflow for len up to 0xFFFF.
- Outside SEND, `sop`, `eop`, `data` and `empty` are all 0.

## Timing
- Reset values (rst=0, asynchronous):
  - State is IDLE.
  - `msg_out.valid`, `sop`, `eop`, `data`, `empty` are 0.
  - `zero_len_indi`=0 and `msg_cnt`=0.
  - `cmd_rdy` is forced to 0 while `rst`=0.
- All `msg_out` outputs and `zero_len_indi` are registered. `cmd_rdy` is a combinational decode of the state, gated by `rst`.
- Latency: a command accepted in cycle t presents the first beat (`valid`=1, `sop`=1) in cycle t+1.
- Backpressure:
  - While `valid`=1 and `rdy`=0, all `msg_out` fields hold stable.
  - A beat advances only on `valid & rdy`.
  - `valid` never drops mid-message.
- Throughput: with `rdy` held high, one beat per cycle and no bubbles inside a message.
- Inter-message gap:
  - eop handshake in cycle t puts the block in IDLE in cycle t+1.
  - The earliest next command accept is cycle t+1; the earliest next sop beat is cycle t+2.
  - `valid`=0 in at least one cycle between messages.
- `cmd_valid` with `cmd_rdy`=0 is ignored; the source holds the command until it is accepted.
- Reset asserted mid-message:
  - Outputs clear immediately and the partial message is abandoned with no eop.
  - `msg_cnt` does not increment.
  - After reset releases, the block is in IDLE.

## Test plan
- W=16, len=40, seed=0x10, `rdy`=1 → 3 beats on consecutive cycles starting the cycle after accept:
  - Beat 0: sop, bytes 0x10..0x1F.
  - Beat 1: bytes 0x20..0x2F.
  - Beat 2: eop, empty=8, bytes 0x30..0x37, low 8 bytes zero.
  - `msg_cnt`=1.
- len=16, seed=0xF8 → one beat with sop=eop=1, empty=0, bytes 0xF8..0xFF, 0x00..0x07 (wrap).
- len=1 → one beat with sop=eop=1, empty=15, MSB byte=seed, rest zero. len=0 → no `valid`, `zero_len_indi` pulses once, `msg_cnt` unchanged.
- len=100 with `rdy` toggling pseudo-randomly → 7 beats, fields stable while `rdy`=0, last beat empty=12. Output fed through `avalon_enforcer` keeps `missing_sop_indi` and `unexpected_sop_indi` at 0 and passes data unchanged.
- Two back-to-back commands (len=17, len=33) with `cmd_valid` held → exactly one `valid`=0 cycle between first eop and second sop, second command accepted in that cycle, `msg_cnt`=2.
- `rst` driven low in the middle of beat 2 of a len=64 message → `valid`/`sop`/`eop` go to 0 asynchronously, `msg_cnt` stays 0. After release, a len=8 command gives a clean single-beat message and `msg_cnt`=1.

Source files
------------

// File: rtl/avalon_msg_generator_if.sv
// Avalon-ST beat bundle: valid/rdy handshake with sop, eop, data and empty.
// readyLatency 0; the first stream byte sits in the MSB byte of data.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic [EMPTY_W-1:0]               empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_msg_generator.sv
// Avalon-ST message source: turns a (length, seed) command into one framed
// message of incrementing bytes, with registered beats and zeroed tail bytes.
module avalon_msg_generator #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_rdy,
  input  logic [15:0] cmd_len_bytes,
  input  logic [7:0]  cmd_seed,
  avalon_st_if.master msg_out,
  output logic        zero_len_indi,
  output logic [15:0] msg_cnt
);
  localparam int          W       = DATA_WIDTH_IN_BYTES;
  localparam int          EMPTY_W = $clog2(W);
  localparam logic [15:0] W16     = 16'(W);
  localparam logic [7:0]  W8      = 8'(W);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [15:0] bytes_left;
  logic [7:0]  next_byte;
  logic [15:0] rem_left;
  logic [7:0]  rem_byte;

  // Bytes beyond the remaining count are forced to zero.
  function automatic logic [W*8-1:0] beat_data(input logic [7:0] first, input logic [15:0] left);
    logic [W*8-1:0] d;
    d = '0;
    for (int i = 0; i < W; i++) begin
      if (16'(i) < left) d[(W-i)*8-1 -: 8] = first + 8'(i);
    end
    return d;
  endfunction

  function automatic logic [EMPTY_W-1:0] beat_empty(input logic [15:0] left);
    if (left >= W16) return '0;
    return EMPTY_W'(W16 - left);
  endfunction

  assign cmd_rdy  = rst & (state == IDLE);
  assign rem_left = bytes_left - W16;
  assign rem_byte = next_byte + W8;

  // Each register holds the beat currently presented; it is rebuilt on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bytes_left    <= '0;
      next_byte     <= '0;
      msg_out.valid <= 1'b0;
      msg_out.sop   <= 1'b0;
      msg_out.eop   <= 1'b0;
      msg_out.data  <= '0;
      msg_out.empty <= '0;
      zero_len_indi <= 1'b0;
      msg_cnt       <= '0;
    end else begin
      zero_len_indi <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_rdy) begin
            if (cmd_len_bytes == 16'd0) begin
              zero_len_indi <= 1'b1;
            end else begin
              state         <= SEND;
              bytes_left    <= cmd_len_bytes;
              next_byte     <= cmd_seed;
              msg_out.valid <= 1'b1;
              msg_out.sop   <= 1'b1;
              msg_out.eop   <= (cmd_len_bytes <= W16);
              msg_out.data  <= beat_data(cmd_seed, cmd_len_bytes);
              msg_out.empty <= beat_empty(cmd_len_bytes);
            end
          end
        end
        SEND: begin
          if (msg_out.rdy) begin
            if (msg_out.eop) begin
              state         <= IDLE;
              msg_out.valid <= 1'b0;
              msg_out.sop   <= 1'b0;
              msg_out.eop   <= 1'b0;
              msg_out.data  <= '0;
              msg_out.empty <= '0;
              msg_cnt       <= msg_cnt + 16'd1;
            end else begin
              bytes_left    <= rem_left;
              next_byte     <= rem_byte;
              msg_out.sop   <= 1'b0;
              msg_out.eop   <= (rem_left <= W16);
              msg_out.data  <= beat_data(rem_byte, rem_left);
              msg_out.empty <= beat_empty(rem_left);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_msg_generator.sv
// Directed bench for avalon_msg_generator at W=16: framing, wrap, zero length,
// backpressure, back-to-back commands and mid-message reset.
module tb_avalon_msg_generator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rdy;
  logic [15:0] cmd_len_bytes = '0;
  logic [7:0]  cmd_seed = '0;
  logic        zero_len_indi;
  logic [15:0] msg_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) msg_if ();

  avalon_msg_generator #(.DATA_WIDTH_IN_BYTES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_rdy       (cmd_rdy),
    .cmd_len_bytes (cmd_len_bytes),
    .cmd_seed      (cmd_seed),
    .msg_out       (msg_if),
    .zero_len_indi (zero_len_indi),
    .msg_cnt       (msg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference beat built from absolute byte position within the message.
  function automatic logic [127:0] exp_beat(input logic [7:0] seed, input int len, input int k);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      if (k*16 + i < len) d[(16-i)*8-1 -: 8] = seed + 8'(k*16 + i);
    end
    return d;
  endfunction

  // Called at a negedge; returns at the negedge where the first beat is visible.
  task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed);
    int n;
    cmd_len_bytes = len;
    cmd_seed      = seed;
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int           k;
    logic         hs, held;
    logic [127:0] p_data;
    logic         p_sop, p_eop;
    logic [3:0]   p_empty;

    msg_if.rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", msg_if.valid, 0);
    chk("rst_sop_eop", {msg_if.sop, msg_if.eop}, 0);
    chk("rst_data", msg_if.data, 0);
    chk("rst_empty", msg_if.empty, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_msg_cnt", msg_cnt, 0);
    chk("rst_zero_len", zero_len_indi, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cmd_rdy", cmd_rdy, 1);

    // len=40 seed=0x10, three consecutive beats
    send_cmd(16'd40, 8'h10);
    chk("t1_b0_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b1, 1'b0, 4'd0});
    chk("t1_b0_data", msg_if.data, 128'h101112131415161718191A1B1C1D1E1F);
    chk("t1_b0_cmd_rdy", cmd_rdy, 0);
    @(negedge clk);
    chk("t1_b1_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b0, 1'b0, 4'd0});
    chk("t1_b1_data", msg_if.data, 128'h202122232425262728292A2B2C2D2E2F);
    @(negedge clk);
    chk("t1_b2_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b0, 1'b1, 4'd8});
    chk("t1_b2_data", msg_if.data, 128'h30313233343536370000000000000000);
    @(negedge clk);
    chk("t1_idle_out", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, 0);
    chk("t1_idle_data", msg_if.data, 0);
    chk("t1_msg_cnt", msg_cnt, 1);

    // len=16 seed=0xF8, byte wrap inside a single beat
    send_cmd(16'd16, 8'hF8);
    chk("t2_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b1, 1'b1, 4'd0});
    chk("t2_data", msg_if.data, 128'hF8F9FAFBFCFDFEFF0001020304050607);
    @(negedge clk);
    chk("t2_msg_cnt", msg_cnt, 2);

    // len=1
    send_cmd(16'd1, 8'hA5);
    chk("t3_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b1, 1'b1, 4'd15});
    chk("t3_data", msg_if.data, 128'hA5000000000000000000000000000000);
    @(negedge clk);
    chk("t3_msg_cnt", msg_cnt, 3);

    // len=0 is dropped with a one-cycle indication
    send_cmd(16'd0, 8'h33);
    chk("t4_zero_pulse", zero_len_indi, 1);
    chk("t4_no_valid", msg_if.valid, 0);
    @(negedge clk);
    chk("t4_zero_clear", zero_len_indi, 0);
    chk("t4_no_valid2", msg_if.valid, 0);
    chk("t4_cmd_rdy", cmd_rdy, 1);
    chk("t4_msg_cnt", msg_cnt, 3);

    // len=100 under random backpressure
    send_cmd(16'd100, 8'h40);
    k = 0;
    held = 1'b0;
    p_data = '0; p_sop = 1'b0; p_eop = 1'b0; p_empty = '0;
    for (int cyc = 0; cyc < 300 && k < 7; cyc++) begin
      chk("t5_valid", msg_if.valid, 1);
      if (held) begin
        chk("t5_hold", {msg_if.sop, msg_if.eop, msg_if.empty, msg_if.data},
            {p_sop, p_eop, p_empty, p_data});
      end
      chk("t5_data", msg_if.data, exp_beat(8'h40, 100, k));
      chk("t5_sop_eop", {msg_if.sop, msg_if.eop}, {k == 0, k == 6});
      if (k == 6) chk("t5_empty", msg_if.empty, 12);
      msg_if.rdy = 1'($urandom_range(0, 1));
      hs      = msg_if.valid & msg_if.rdy;
      held    = msg_if.valid & ~msg_if.rdy;
      p_data  = msg_if.data;
      p_sop   = msg_if.sop;
      p_eop   = msg_if.eop;
      p_empty = msg_if.empty;
      @(posedge clk);
      if (hs) k++;
      @(negedge clk);
    end
    msg_if.rdy = 1'b1;
    chk("t5_beats", k, 7);
    chk("t5_after_valid", msg_if.valid, 0);
    chk("t5_msg_cnt", msg_cnt, 4);

    // back-to-back: len=17 then len=33 with cmd_valid held
    cmd_len_bytes = 16'd17;
    cmd_seed      = 8'h00;
    cmd_valid     = 1'b1;
    chk("t6_rdy0", cmd_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_len_bytes = 16'd33;
    cmd_seed      = 8'h80;
    chk("t6_m1_b0", {msg_if.valid, msg_if.sop, msg_if.eop}, 3'b110);
    chk("t6_m1_b0_data", msg_if.data, exp_beat(8'h00, 17, 0));
    @(negedge clk);
    chk("t6_m1_b1", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b0, 1'b1, 4'd15});
    chk("t6_m1_b1_data", msg_if.data, 128'h10000000000000000000000000000000);
    @(negedge clk);
    chk("t6_gap_valid", msg_if.valid, 0);
    chk("t6_gap_cmd_rdy", cmd_rdy, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_m2_b0", {msg_if.valid, msg_if.sop, msg_if.eop}, 3'b110);
    chk("t6_m2_b0_byte", msg_if.data[127:120], 8'h80);
    @(negedge clk);
    chk("t6_m2_b1", {msg_if.valid, msg_if.sop, msg_if.eop}, 3'b100);
    @(negedge clk);
    chk("t6_m2_b2", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b0, 1'b1, 4'd15});
    chk("t6_m2_b2_data", msg_if.data, 128'hA0000000000000000000000000000000);
    @(negedge clk);
    chk("t6_end_valid", msg_if.valid, 0);
    chk("t6_msg_cnt", msg_cnt, 6);

    // reset in the middle of beat 2 of a len=64 message
    send_cmd(16'd64, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t7_b2_before", {msg_if.valid, msg_if.eop}, 2'b10);
    chk("t7_b2_data", msg_if.data, exp_beat(8'h00, 64, 2));
    #2 rst = 1'b0;
    #1;
    chk("t7_async_clear", {msg_if.valid, msg_if.sop, msg_if.eop}, 0);
    chk("t7_async_data", msg_if.data, 0);
    chk("t7_cmd_rdy_low", cmd_rdy, 0);
    chk("t7_msg_cnt", msg_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_idle_valid", msg_if.valid, 0);
    send_cmd(16'd8, 8'h55);
    chk("t7_ctl", {msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty}, {1'b1, 1'b1, 1'b1, 4'd8});
    chk("t7_data", msg_if.data, 128'h55565758595A5B5C0000000000000000);
    @(negedge clk);
    chk("t7_msg_cnt_after", msg_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
